keccak_unpadder: RTL
====================

# keccak_unpadder

Receive-side counterpart of the padder: accepts 64-bit words of a Keccak rate block (576 bits = 9 words), buffers the full block, and, for the final block, strips the pad10*1 padding. It emits the message words with a byte count on the last word, in the same `byte_num` convention the padder consumes. It sits after the block transport on the verification and loopback path, in front of the message sink.

## Interface
- No parameters; rate fixed at 9 words.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- in  in  64  input word; byte 0 = bits 7:0 = first message byte.
- in_valid  in  1  `in` / `in_last` valid.
- in_last  in  1  block is the final block; sampled with word 0 only.
- in_ready  out  1  word accepted when `in_valid & in_ready`.
- out  out  64  message word; pad bytes forced to 0.
- out_valid  out  1  `out` / `out_last` / `byte_num` valid.
- out_ready  in  1  word consumed when `out_valid & out_ready`.
- out_last  out  1  last message word.
- byte_num  out  3  message bytes in the last word, 0..7; meaningful only with `out_last`; non-last words carry 8 bytes.
- pad_err  out  1  sticky malformed-padding flag; cleared only by reset.

## Operation
- Buffer: 9×64 register array, write index `wcnt` 0..8, read index `rcnt`, end index `eidx`, end byte `ebyte`, final flag.
- State FILL:
  - `in_ready`=1.
  - Each accepted word is stored at `wcnt`, then `wcnt` increments.
  - `in_last` is latched into the final flag on `wcnt`=0.
  - When word 8 is accepted, the next state is EMIT with `eidx`=8 if the block is non-final, otherwise SCAN.
- State SCAN, final block only:
  - Check bit 63 of word 8. If it is 0, set `pad_err` and go to FILL; the block is discarded.
  - Otherwise walk words from index 8 downward, one word per cycle. Word 8 is examined with bit 63 masked.
  - On the first word with a nonzero byte, locate the highest nonzero byte `b` with a priority encoder. That byte must equal 0x01, or 0x00 after masking in word 8. Latch `eidx`=word index and `ebyte`=`b`, then go to EMIT.
  - If the byte is any other value, or all words are zero, set `pad_err` and go to FILL.
- State EMIT:
  - `out_valid`=1; `out` = buffer[`rcnt`].
  - For the word at `eidx` of a final block: bytes at and above `ebyte` read as 0, `out_last`=1, `byte_num`=`ebyte`.
  - For non-final blocks, `out_last`=0 on every word.
  - Words above `eidx` are never emitted.
  - When the word at `eidx` is handed off, clear `rcnt` and `wcnt` and go to FILL.
- `pad_err` does not block further operation.

## Timing
- Reset values:
  - state FILL; `in_ready`=1.
  - `out_valid`=0; `out`=0; `out_last`=0; `byte_num`=0; `pad_err`=0.
  - All counters 0.
- `in_ready`=0 in SCAN and EMIT; there is no overlap of FILL with EMIT.
- Latency from acceptance of word 8 to the first `out_valid`:
  - 1 cycle for a non-final block.
  - 1 + k cycles for a final block, where k = 1..9 scan steps (k = 9 − `eidx`).
- Outputs are registered.
- `out`, `out_last` and `byte_num` hold stable while `out_valid` is high and `out_ready` is low.
- `out_valid` may not drop without a handshake.
- Reset deasserted mid-block restarts cleanly in FILL with the buffer contents ignored.

## Test plan
- Non-final block with words 0x0..0x8 (value = index), `out_ready`=1:
  - 9 outputs 0x0..0x8 on consecutive cycles, `out_last`=0 throughout.
- Final block, 3-byte message:
  - Input: word0=0x0000000001ABCDEF, words 1–7=0, word8=0x8000000000000000.
  - Required: after 9 scan cycles, exactly one output `out`=0x0000000000ABCDEF, `byte_num`=3, `out_last`=1.
- Final block, 71-byte message:
  - Input: words 0–7=0x1234567890ABCDEF, word8=0x81CDEF1234567890.
  - Required: 9 outputs; the last is 0x00CDEF1234567890 with `byte_num`=7 and `out_last`=1, after 1 scan cycle.
- Final block, 64-byte message:
  - Input: word8=0x8000000000000001.
  - Required: 9 outputs; the last is `out`=0 with `byte_num`=0 and `out_last`=1.
- Empty message:
  - Input: word0=0x01, word8=0x8000000000000000.
  - Required: one output, 0 with `byte_num`=0 and `out_last`=1.
- Errors:
  - word8 bit 63 clear → `pad_err`=1 and no `out_valid`.
  - Highest byte 0x02 → `pad_err`=1 and no `out_valid`.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles mid-EMIT → `out` stays stable, no words lost.
- Reset:
  - Reset asserted after 4 input words → outputs return to their reset values.
  - The next full non-final block then emits normally.

Source files
------------

// File: rtl/keccak_unpadder.sv
// keccak_unpadder: buffers one 9-word Keccak rate block, strips the pad10*1
// padding from a final block and re-emits the message words, flagging the
// last word with its byte count in the same convention the padder consumes.
module keccak_unpadder (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [2:0]  byte_num,
    output logic        pad_err
);
    typedef enum logic [1:0] {FILL = 2'd0, SCAN = 2'd1, EMIT = 2'd2} state_t;

    localparam logic [3:0] LAST_IDX = 4'd8;

    state_t      state_reg, state_next;
    logic [63:0] buffer [0:8];
    logic [3:0]  wcnt_reg, rcnt_reg, sidx_reg, eidx_reg;
    logic [2:0]  ebyte_reg;
    logic        final_reg, at_end_reg;
    logic [63:0] out_reg;
    logic        out_valid_reg, out_last_reg, pad_err_reg;
    logic [2:0]  byte_num_reg;

    logic        accept;
    logic [63:0] scan_word;
    logic [7:0]  byte_nz;
    logic [2:0]  top_byte;
    logic [7:0]  top_val;
    logic        scan_found, scan_fail, scan_next;
    logic        emit_load, emit_done, emit_last;
    logic [63:0] keep_mask, emit_word;

    assign accept    = (state_reg == FILL) && in_valid;
    assign in_ready  = (state_reg == FILL);
    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign byte_num  = byte_num_reg;
    assign pad_err   = pad_err_reg;

    // Block storage; contents are only meaningful for indices below wcnt.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[wcnt_reg] <= in;
        end
    end

    // Word under examination during the scan; the closing pad bit of word 8 is hidden.
    always_comb begin
        scan_word = buffer[sidx_reg];
        if (sidx_reg == LAST_IDX) begin
            scan_word[63] = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_nz
            assign byte_nz[gi] = |scan_word[gi*8 +: 8];
        end
    endgenerate

    // Priority encoder: highest nonzero byte of the scanned word.
    always_comb begin
        top_byte = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (byte_nz[i]) begin
                top_byte = 3'(i);
            end
        end
        top_val = scan_word[{top_byte, 3'b000} +: 8];
    end

    // Scan step outcome: found the pad start, malformed padding, or keep walking down.
    always_comb begin
        scan_found = 1'b0;
        scan_fail  = 1'b0;
        scan_next  = 1'b0;
        if (state_reg == SCAN) begin
            if ((sidx_reg == LAST_IDX) && !buffer[LAST_IDX][63]) begin
                scan_fail = 1'b1;
            end else if (|byte_nz) begin
                if (top_val == 8'h01) begin
                    scan_found = 1'b1;
                end else begin
                    scan_fail = 1'b1;
                end
            end else if (sidx_reg == 4'd0) begin
                scan_fail = 1'b1;
            end else begin
                scan_next = 1'b1;
            end
        end
    end

    // Output word selection; pad bytes of the final word read as zero.
    always_comb begin
        emit_load = (state_reg == EMIT) && (!out_valid_reg || (out_ready && !at_end_reg));
        emit_done = (state_reg == EMIT) && out_valid_reg && out_ready && at_end_reg;
        emit_last = final_reg && (rcnt_reg == eidx_reg);
        keep_mask = (64'd1 << {ebyte_reg, 3'b000}) - 64'd1;
        emit_word = emit_last ? (buffer[rcnt_reg] & keep_mask) : buffer[rcnt_reg];
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FILL: if (accept && (wcnt_reg == LAST_IDX)) state_next = final_reg ? SCAN : EMIT;
            SCAN: begin
                if (scan_fail) state_next = FILL;
                else if (scan_found) state_next = EMIT;
            end
            EMIT: if (emit_done) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Counters, scan results and registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_reg      <= 4'd0;
            rcnt_reg      <= 4'd0;
            sidx_reg      <= 4'd0;
            eidx_reg      <= 4'd0;
            ebyte_reg     <= 3'd0;
            final_reg     <= 1'b0;
            at_end_reg    <= 1'b0;
            out_reg       <= 64'd0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            byte_num_reg  <= 3'd0;
            pad_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                wcnt_reg <= wcnt_reg + 4'd1;
                if (wcnt_reg == 4'd0) final_reg <= in_last;
                if (wcnt_reg == LAST_IDX) begin
                    eidx_reg <= LAST_IDX;
                    sidx_reg <= LAST_IDX;
                end
            end
            if (scan_next) sidx_reg <= sidx_reg - 4'd1;
            if (scan_found) begin
                eidx_reg  <= sidx_reg;
                ebyte_reg <= top_byte;
            end
            if (scan_fail) begin
                pad_err_reg <= 1'b1;
                wcnt_reg    <= 4'd0;
            end
            if (emit_load) begin
                out_reg       <= emit_word;
                out_valid_reg <= 1'b1;
                out_last_reg  <= emit_last;
                byte_num_reg  <= emit_last ? ebyte_reg : 3'd0;
                at_end_reg    <= (rcnt_reg == eidx_reg);
                rcnt_reg      <= rcnt_reg + 4'd1;
            end
            if (emit_done) begin
                out_reg       <= 64'd0;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
                byte_num_reg  <= 3'd0;
                at_end_reg    <= 1'b0;
                rcnt_reg      <= 4'd0;
                wcnt_reg      <= 4'd0;
            end
        end
    end
endmodule
